scoreboard_hazard_unit: RTL and testbench

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

---
 rtl/scoreboard_hazard_unit_if.sv | 46 ++++
 rtl/scoreboard_hazard_unit.sv | 103 ++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_hazard_unit_if.sv
// Decode/EX hazard bundle between the issue stage and the scoreboard.
// master = decode/EX side driving requests; slave = hazard unit.
interface scoreboard_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 4,
  parameter int PERF_W = 32
);
  logic              d_valid;
  logic [REG_AW-1:0] d_rs1;
  logic [REG_AW-1:0] d_rs2;
  logic [REG_AW-1:0] d_rd;
  logic              d_rs1_used;
  logic              d_rs2_used;
  logic              d_reg_we;
  logic [LAT_W-1:0]  d_lat;
  logic              e_b_taken;
  logic              var_done;
  logic [REG_AW-1:0] var_rd;
  logic              forward_rs1;
  logic              forward_rs2;
  logic              stall_f;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output d_valid, d_rs1, d_rs2, d_rd,
    output d_rs1_used, d_rs2_used, d_reg_we,
    output d_lat, e_b_taken, var_done, var_rd,
    input  forward_rs1, forward_rs2,
    input  stall_f, stall_if_id,
    input  flush_if_id, flush_id_ex,
    input  stall_cycles
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_rd,
    input  d_rs1_used, d_rs2_used, d_reg_we,
    input  d_lat, e_b_taken, var_done, var_rd,
    output forward_rs1, forward_rs2,
    output stall_f, stall_if_id,
    output flush_if_id, flush_id_ex,
    output stall_cycles
  );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Register scoreboard: RAW/WAW stall, writeback forward, branch flush.
// Ports: clk, rst (sync high), sb (slave: decode request in, hazards out).
module scoreboard_hazard_unit #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int LAT_W    = 4,
  parameter int PERF_W   = 32
) (
  input logic clk,
  input logic rst,
  scoreboard_hazard_unit_if.slave sb
);
  localparam int NS = 2 ** REG_AW;

  logic [NS-1:0]     busy;
  logic [NS-1:0]     vr;
  logic [LAT_W-1:0]  cnt [NS];
  logic [NS-1:0]     rdy;
  logic [PERF_W-1:0] perf;

  logic rs1_hz;
  logic rs2_hz;
  logic raw;
  logic waw;
  logic stall;
  logic issue;

  // Result for r is on the writeback bus this cycle (or r is free).
  always_comb begin
    rdy = '1;
    for (int r = 0; r < NS; r++) begin
      rdy[r] = ~busy[r]
             | (~vr[r] & (cnt[r] == LAT_W'(1)))
             | (vr[r] & sb.var_done
                & (sb.var_rd == REG_AW'(r)));
    end
  end

  always_comb begin
    rs1_hz = sb.d_rs1_used & (sb.d_rs1 != '0)
           & ~rdy[sb.d_rs1];
    rs2_hz = sb.d_rs2_used & (sb.d_rs2 != '0)
           & ~rdy[sb.d_rs2];
    raw = sb.d_valid & (rs1_hz | rs2_hz);
    // A new write must not land before an older one still in flight.
    waw = sb.d_valid & sb.d_reg_we
        & (sb.d_rd != '0) & busy[sb.d_rd]
        & (vr[sb.d_rd] | (sb.d_lat == '0)
           | (cnt[sb.d_rd] >= sb.d_lat));
    stall = (raw | waw) & ~sb.e_b_taken;
    issue = sb.d_valid & ~stall & ~sb.e_b_taken;
  end

  assign sb.stall_f     = stall;
  assign sb.stall_if_id = stall;
  assign sb.flush_if_id = sb.e_b_taken;
  assign sb.flush_id_ex = sb.e_b_taken | stall;
  assign sb.stall_cycles = perf;

  assign sb.forward_rs1 = sb.d_rs1_used
                        & (sb.d_rs1 != '0)
                        & busy[sb.d_rs1]
                        & rdy[sb.d_rs1];
  assign sb.forward_rs2 = sb.d_rs2_used
                        & (sb.d_rs2 != '0)
                        & busy[sb.d_rs2]
                        & rdy[sb.d_rs2];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      vr   <= '0;
      perf <= '0;
      for (int r = 0; r < NS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      if (stall && !(&perf)) begin
        perf <= perf + PERF_W'(1);
      end
      for (int r = 1; r < NUM_REGS; r++) begin
        if (busy[r] && !vr[r]) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
          if (cnt[r] == LAT_W'(1)) begin
            busy[r] <= 1'b0;
          end
        end
        if (busy[r] && vr[r] && sb.var_done
            && (sb.var_rd == REG_AW'(r))) begin
          busy[r] <= 1'b0;
          vr[r]   <= 1'b0;
        end
        // Later assignment: a new issue overrides a same-cycle clear.
        if (issue && sb.d_reg_we
            && (sb.d_rd == REG_AW'(r))) begin
          busy[r] <= 1'b1;
          cnt[r]  <= sb.d_lat;
          vr[r]   <= (sb.d_lat == '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: time-based reference model
// checked every cycle, plus directed literal checks.
module tb_scoreboard_hazard_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scoreboard_hazard_unit_if #(
    .REG_AW(5), .LAT_W(4), .PERF_W(32)
  ) sbi ();

  scoreboard_hazard_unit #(
    .NUM_REGS(32), .REG_AW(5), .LAT_W(4), .PERF_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (sbi)
  );

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  // Model: fixed-latency write to r completes (on bus) at cycle md[r].
  bit mf [32];
  bit mv [32];
  int md [32];
  int now   = 0;
  int mperf = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic bit m_busy(input int r);
    return (r != 0) && (mf[r] || mv[r]);
  endfunction

  function automatic bit m_ready(input int r);
    if (r == 0) return 1'b1;
    if (mv[r])
      return sbi.var_done && (int'(sbi.var_rd) == r);
    if (mf[r]) return md[r] == now;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    bit raw, waw, stl, iss, fw1, fw2;
    int rs1, rs2, rd, lat, rem;
    rs1 = int'(sbi.d_rs1);
    rs2 = int'(sbi.d_rs2);
    rd  = int'(sbi.d_rd);
    lat = int'(sbi.d_lat);
    rem = md[rd] - now + 1;
    raw = sbi.d_valid
        && ((sbi.d_rs1_used && !m_ready(rs1))
         || (sbi.d_rs2_used && !m_ready(rs2)));
    waw = sbi.d_valid && sbi.d_reg_we && m_busy(rd)
        && (mv[rd] || lat == 0 || rem >= lat);
    stl = (raw || waw) && !sbi.e_b_taken;
    iss = sbi.d_valid && !stl && !sbi.e_b_taken;
    fw1 = sbi.d_rs1_used && m_busy(rs1) && m_ready(rs1);
    fw2 = sbi.d_rs2_used && m_busy(rs2) && m_ready(rs2);
    if (mon_on) begin
      chk("m_stall_f", 64'(sbi.stall_f), 64'(stl));
      chk("m_stall_ifid", 64'(sbi.stall_if_id), 64'(stl));
      chk("m_flush_ifid", 64'(sbi.flush_if_id),
          64'(sbi.e_b_taken));
      chk("m_flush_idex", 64'(sbi.flush_id_ex),
          64'(stl || sbi.e_b_taken));
      chk("m_fwd1", 64'(sbi.forward_rs1), 64'(fw1));
      chk("m_fwd2", 64'(sbi.forward_rs2), 64'(fw2));
      chk("m_perf", 64'(sbi.stall_cycles), 64'(mperf));
    end
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        mf[r] = 1'b0;
        mv[r] = 1'b0;
      end
      mperf = 0;
    end else begin
      if (stl) mperf++;
      for (int r = 1; r < 32; r++) begin
        if (mf[r] && md[r] == now) mf[r] = 1'b0;
        if (mv[r] && sbi.var_done
            && int'(sbi.var_rd) == r) mv[r] = 1'b0;
      end
      if (iss && sbi.d_reg_we && rd != 0) begin
        mv[rd] = (lat == 0);
        mf[rd] = (lat != 0);
        md[rd] = now + lat;
      end
    end
    now++;
  end

  task automatic idle();
    sbi.d_valid    = 1'b0;
    sbi.d_rs1      = '0;
    sbi.d_rs2      = '0;
    sbi.d_rd       = '0;
    sbi.d_rs1_used = 1'b0;
    sbi.d_rs2_used = 1'b0;
    sbi.d_reg_we   = 1'b0;
    sbi.d_lat      = '0;
    sbi.e_b_taken  = 1'b0;
    sbi.var_done   = 1'b0;
    sbi.var_rd     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic put_wr(input int rd, input int lat);
    idle();
    sbi.d_valid  = 1'b1;
    sbi.d_reg_we = 1'b1;
    sbi.d_rd     = 5'(rd);
    sbi.d_lat    = 4'(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    idle();
    tick();
    tick();
    mon_on = 1'b1;
    tick();
    #1;
    chk("rst_stall", 64'(sbi.stall_f), 64'd0);
    chk("rst_flush", 64'(sbi.flush_id_ex), 64'd0);
    chk("rst_fwd", 64'(sbi.forward_rs1), 64'd0);
    chk("rst_perf", 64'(sbi.stall_cycles), 64'd0);
    rst = 1'b0;
    tick();

    // Fixed latency 3: result on bus two cycles after first use.
    put_wr(5, 3);
    #1 chk("iss5_stall", 64'(sbi.stall_f), 64'd0);
    tick();
    idle();
    sbi.d_valid    = 1'b1;
    sbi.d_rs1_used = 1'b1;
    sbi.d_rs1      = 5'd5;
    #1 chk("raw5_stall", 64'(sbi.stall_f), 64'd1);
    chk("raw5_flush", 64'(sbi.flush_id_ex), 64'd1);
    chk("raw5_fwd0", 64'(sbi.forward_rs1), 64'd0);
    tick();
    #1 chk("raw5_stall2", 64'(sbi.stall_f), 64'd1);
    tick();
    #1 chk("raw5_go", 64'(sbi.stall_f), 64'd0);
    chk("raw5_fwd", 64'(sbi.forward_rs1), 64'd1);
    tick();
    #1 chk("post5_fwd", 64'(sbi.forward_rs1), 64'd0);
    chk("post5_stall", 64'(sbi.stall_f), 64'd0);
    tick();

    // Variable latency: stall until var_done.
    do_reset();
    put_wr(7, 0);
    tick();
    idle();
    sbi.d_valid    = 1'b1;
    sbi.d_rs2_used = 1'b1;
    sbi.d_rs2      = 5'd7;
    n = 0;
    repeat (10) begin
      #1 if (sbi.stall_f) n++;
      tick();
    end
    chk("var_nstall", 64'(n), 64'd10);
    #1 chk("var_perf", 64'(sbi.stall_cycles), 64'd10);
    sbi.var_done = 1'b1;
    sbi.var_rd   = 5'd7;
    #1 chk("var_go", 64'(sbi.stall_f), 64'd0);
    chk("var_fwd2", 64'(sbi.forward_rs2), 64'd1);
    tick();
    sbi.var_done = 1'b0;
    #1 chk("var_clr_fwd", 64'(sbi.forward_rs2), 64'd0);
    chk("var_clr_stall", 64'(sbi.stall_f), 64'd0);
    tick();

    // WAW: busy rd=3 with cnt 4, new lat 2 waits until cnt 1.
    do_reset();
    put_wr(3, 5);
    tick();
    idle();
    tick();
    put_wr(3, 2);
    #1 chk("waw_c4", 64'(sbi.stall_f), 64'd1);
    tick();
    #1 chk("waw_c3", 64'(sbi.stall_f), 64'd1);
    tick();
    #1 chk("waw_c2", 64'(sbi.stall_f), 64'd1);
    tick();
    #1 chk("waw_c1", 64'(sbi.stall_f), 64'd0);
    tick();
    do_reset();
    put_wr(3, 6);
    tick();
    idle();
    tick();
    tick();
    put_wr(3, 5);
    #1 chk("waw_long", 64'(sbi.stall_f), 64'd0);
    tick();

    // Register 0 is never a hazard.
    idle();
    sbi.d_valid    = 1'b1;
    sbi.d_rs1_used = 1'b1;
    sbi.d_rs2_used = 1'b1;
    sbi.d_reg_we   = 1'b1;
    sbi.var_done   = 1'b1;
    #1 chk("z_stall", 64'(sbi.stall_f), 64'd0);
    chk("z_fwd1", 64'(sbi.forward_rs1), 64'd0);
    chk("z_fwd2", 64'(sbi.forward_rs2), 64'd0);
    tick();

    // Taken branch beats a RAW stall and blocks issue.
    do_reset();
    put_wr(9, 4);
    tick();
    put_wr(10, 2);
    sbi.d_rs1_used = 1'b1;
    sbi.d_rs1      = 5'd9;
    sbi.e_b_taken  = 1'b1;
    #1 chk("br_stall", 64'(sbi.stall_f), 64'd0);
    chk("br_fifid", 64'(sbi.flush_if_id), 64'd1);
    chk("br_fidex", 64'(sbi.flush_id_ex), 64'd1);
    tick();
    idle();
    sbi.d_valid    = 1'b1;
    sbi.d_rs1_used = 1'b1;
    sbi.d_rs1      = 5'd10;
    #1 chk("br_noent", 64'(sbi.stall_f), 64'd0);
    chk("br_nofwd", 64'(sbi.forward_rs1), 64'd0);
    tick();

    // Reset with ops in flight and a same-cycle issue.
    do_reset();
    put_wr(11, 8);
    tick();
    put_wr(12, 0);
    tick();
    put_wr(13, 9);
    tick();
    idle();
    sbi.d_valid    = 1'b1;
    sbi.d_rs1_used = 1'b1;
    sbi.d_rs1      = 5'd12;
    tick();
    tick();
    #1 chk("pre_perf", 64'(sbi.stall_cycles), 64'd2);
    put_wr(14, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    put_wr(13, 3);
    sbi.d_rs1_used = 1'b1;
    sbi.d_rs1      = 5'd11;
    sbi.d_rs2_used = 1'b1;
    sbi.d_rs2      = 5'd14;
    #1 chk("post_rst_stall", 64'(sbi.stall_f), 64'd0);
    chk("post_rst_perf", 64'(sbi.stall_cycles), 64'd0);
    tick();
    idle();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
